regfile_dump_reader: RTL and testbench

Debug and verification read-out engine for the RV32I register file. On a `start` pulse it walks every architectural register through the register file's two read ports (`rs1`/`rs2` addressing, `output1`/`output2` data) and streams each `{address, value}` pair out over a valid/ready interface. It sits beside the decode stage and shares the read ports through a mux owned by the core. It is the read-side counterpart of the write-back path that drives `regWrite`/`rd`/`data`.

---
 rtl/regfile_dump_reader.sv | 127 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump_reader
//  Purpose  : Walks the register file two entries at a time through its read
//             ports and streams {address, value} words over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,   // even, >= 2
    parameter int ADDR_W   = 5,    // 2**ADDR_W >= NUM_REGS
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rs1,
    output logic [ADDR_W-1:0] rs2,
    input  logic [DATA_W-1:0] output1,
    input  logic [DATA_W-1:0] output2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    // One spare index bit so the end-of-dump compare never sees a wrap.
    localparam int                c_IDX_W = ADDR_W + 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EMIT0 = 3'd2,
        S_EMIT1 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [c_IDX_W-1:0] r_idx_q,   w_idx_d;
    logic [DATA_W-1:0]  r_buf0_q,  w_buf0_d;
    logic [DATA_W-1:0]  r_buf1_q,  w_buf1_d;
    logic [ADDR_W-1:0]  w_idx_lo;
    logic [c_IDX_W-1:0] w_idx_p2;

    assign w_idx_lo = r_idx_q[ADDR_W-1:0];
    assign w_idx_p2 = r_idx_q + c_IDX_W'(2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= S_IDLE;
            r_idx_q   <= '0;
            r_buf0_q  <= '0;
            r_buf1_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_buf0_q  <= w_buf0_d;
            r_buf1_q  <= w_buf1_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        w_buf0_d  = r_buf0_q;
        w_buf1_d  = r_buf1_q;
        rs1       = '0;
        rs2       = '0;
        out_valid = 1'b0;
        out_addr  = '0;
        out_data  = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_state_d = S_FETCH;
                    w_idx_d   = '0;
                end
            end
            S_FETCH: begin
                busy      = 1'b1;
                rs1       = w_idx_lo;
                rs2       = w_idx_lo + ADDR_W'(1);
                w_buf0_d  = output1;
                w_buf1_d  = output2;
                w_state_d = S_EMIT0;
            end
            S_EMIT0: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_addr  = w_idx_lo;
                out_data  = r_buf0_q;
                if (out_ready) begin
                    w_state_d = S_EMIT1;
                end
            end
            S_EMIT1: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_addr  = w_idx_lo + ADDR_W'(1);
                out_data  = r_buf1_q;
                if (out_ready) begin
                    if (w_idx_p2 == c_LAST) begin
                        w_state_d = S_DONE;
                    end else begin
                        w_idx_d   = w_idx_p2;
                        w_state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_dump_reader
//  Purpose  : Directed + randomized-backpressure bench with a register-file
//             model and a snapshot-based expected word stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_dump_reader;

    localparam int c_N = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  rs1, rs2, out_addr;
    logic [31:0] output1, output2, out_data;
    logic        out_valid, busy, done;

    logic        start2 = 1'b0;
    logic [4:0]  rs1_2, rs2_2, out_addr_2;
    logic [31:0] output1_2, output2_2, out_data_2;
    logic        out_valid_2, busy_2, done_2;

    logic [31:0] regs [c_N];

    assign output1   = regs[rs1];
    assign output2   = regs[rs2];
    assign output1_2 = regs[rs1_2];
    assign output2_2 = regs[rs2_2];

    always #5 clk = ~clk;

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rs1(rs1), .rs2(rs2), .output1(output1), .output2(output2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    regfile_dump_reader #(.NUM_REGS(2), .ADDR_W(5), .DATA_W(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .rs1(rs1_2), .rs2(rs2_2), .output1(output1_2), .output2(output2_2),
        .out_valid(out_valid_2), .out_ready(1'b1),
        .out_addr(out_addr_2), .out_data(out_data_2),
        .busy(busy_2), .done(done_2)
    );

    int checks = 0;
    int failures = 0;

    int          got_addr [$];
    logic [31:0] got_data [$];
    int          got_cyc  [$];
    int          busy_cnt, stalls, done_cnt, done_cyc, addr5_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ready_mode: 0 = always ready, 1 = random, 2 = stall 3 cycles on addr 5
    task automatic run_dump(input int ready_mode, input bit restart10, input bit write20);
        logic [31:0] snap [c_N];
        logic        pv, pr, v, rdy;
        logic [4:0]  pa;
        logic [31:0] pd;
        int          stall_left, exp_busy;
        for (int i = 0; i < c_N; i++) snap[i] = regs[i];
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        busy_cnt = 0; stalls = 0; done_cnt = 0; done_cyc = -1; addr5_cnt = 0;
        stall_left = 3; pv = 1'b0; pr = 1'b0; pa = '0; pd = '0;

        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = restart10 && (c == 10);
            if (write20 && c == 20) regs[4] = 32'd15;
            v = out_valid;
            if (pv && !pr) begin
                chk("hold_valid", {63'd0, v}, 64'd1);
                chk("hold_addr", {59'd0, out_addr}, {59'd0, pa});
                chk("hold_data", {32'd0, out_data}, {32'd0, pd});
            end
            if (c == 1) begin
                chk("fetch_rs1", {59'd0, rs1}, 64'd0);
                chk("fetch_rs2", {59'd0, rs2}, 64'd1);
            end
            if (v && (c < 8)) chk("emit_rs_zero", {54'd0, rs1, rs2}, 64'd0);
            if (v && out_addr == 5'd5) addr5_cnt++;
            case (ready_mode)
                1: rdy = 1'($urandom_range(0, 1));
                2: begin
                    rdy = 1'b1;
                    if (v && out_addr == 5'd5 && stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end
                end
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;
            if (busy) busy_cnt++;
            if (v && !rdy) stalls++;
            if (v && rdy) begin
                got_addr.push_back(int'(out_addr));
                got_data.push_back(out_data);
                got_cyc.push_back(c);
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            pv = v; pr = rdy; pa = out_addr; pd = out_data;
            if (done_cyc > 0 && c >= done_cyc + 3) break;
        end
        start = 1'b0;
        out_ready = 1'b1;

        chk("dump_timeout", {63'd0, done_cyc > 0}, 64'd1);
        chk("word_count", 64'(got_addr.size()), 64'(c_N));
        for (int k = 0; k < got_addr.size() && k < c_N; k++) begin
            chk($sformatf("addr[%0d]", k), 64'(got_addr[k]), 64'(k));
            chk($sformatf("data[%0d]", k), {32'd0, got_data[k]}, {32'd0, snap[k]});
            if (ready_mode == 0)
                chk($sformatf("cyc[%0d]", k), 64'(got_cyc[k]), 64'(3 * (k / 2) + 2 + (k % 2)));
        end
        // Each pair costs FETCH+EMIT0+EMIT1, plus DONE, plus one per stalled cycle.
        exp_busy = 3 * (c_N / 2) + 1 + stalls;
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("done_cycle", 64'(done_cyc), 64'(exp_busy));
        chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    endtask

    initial begin
        int w2;
        bit found;
        regs[0] = 32'd0;
        for (int i = 1; i < c_N; i++) regs[i] = 32'(i * 4);
        regs[1] = 32'd10;
        regs[2] = 32'd10;
        regs[31] = 32'hDEADBEEF;

        #12;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_rs", {54'd0, rs1, rs2}, 64'd0);
        chk("rst_out", {27'd0, out_addr, out_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Plain dump with continuous ready.
        run_dump(0, 1'b0, 1'b0);
        chk("x0_data", {32'd0, got_data[0]}, 64'd0);
        chk("x1_data", {32'd0, got_data[1]}, 64'd10);
        chk("x31_data", {32'd0, got_data[31]}, 64'hDEADBEEF);

        // Three-cycle stall on addr 5.
        run_dump(2, 1'b0, 1'b0);
        chk("stall_addr5_cycles", 64'(addr5_cnt), 64'd4);
        chk("stall_busy52", 64'(busy_cnt), 64'd52);

        // Restart pulse mid-dump is ignored; late write to x4 is not seen.
        run_dump(0, 1'b1, 1'b1);
        chk("x4_old", {32'd0, got_data[4]}, 64'd16);
        run_dump(0, 1'b0, 1'b0);
        chk("x4_new", {32'd0, got_data[4]}, 64'd15);

        // Randomized backpressure with new random register contents.
        for (int i = 1; i < c_N; i++) regs[i] = $urandom;
        run_dump(1, 1'b0, 1'b0);
        run_dump(1, 1'b0, 1'b0);

        // Asynchronous reset while addr 9 is presented.
        @(negedge clk);
        start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_addr == 5'd9) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_addr9", {63'd0, found}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_rs", {54'd0, rs1, rs2}, 64'd0);
        chk("arst_out", {27'd0, out_addr, out_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_dump(0, 1'b0, 1'b0);

        // Two-register instance.
        regs[0] = 32'd0;
        regs[1] = 32'h1234_5678;
        w2 = 0;
        done_cnt = 0;
        @(negedge clk);
        start2 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (c == 1) begin
                chk("n2_rs1", {59'd0, rs1_2}, 64'd0);
                chk("n2_rs2", {59'd0, rs2_2}, 64'd1);
            end
            if (out_valid_2) begin
                chk("n2_addr", {59'd0, out_addr_2}, 64'(w2));
                chk("n2_data", {32'd0, out_data_2}, {32'd0, regs[w2 % 2]});
                chk("n2_cyc", 64'(c), 64'(2 + w2));
                w2++;
            end
            if (done_2) begin
                chk("n2_done_cyc", 64'(c), 64'd4);
                done_cnt++;
            end
        end
        chk("n2_words", 64'(w2), 64'd2);
        chk("n2_done_count", 64'(done_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
